// File: rtl/crc_pkg.sv
// Shared types and defaults for the CRC-8 receive framer and its byte-step helper.
package crc_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLen,
        StPayload,
        StCheck,
        StDone,
        StErr
    } rx_state_e;

    localparam logic [7:0]  DefaultPoly    = 8'h07;
    localparam logic [7:0]  DefaultCrcInit = 8'h00;
    localparam logic [7:0]  DefaultSofByte = 8'h7E;
    localparam int unsigned DefaultMaxLen  = 16;

    // Length counter must hold every value in 0..max_len.
    function automatic int unsigned len_cnt_width(input int unsigned max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/crc8_byte_step.sv
// Combinational CRC-8 update over one byte, MSB-first, non-reflected.
module crc8_byte_step
    import crc_pkg::*;
#(
    parameter logic [7:0] POLY = DefaultPoly
) (
    input  logic [7:0] crc_in,
    input  logic [7:0] byte_in,
    output logic [7:0] crc_out
);

    always_comb begin
        crc_out = crc_in ^ byte_in;
        for (int i = 0; i < 8; i++) begin
            crc_out = crc_out[7] ? ({crc_out[6:0], 1'b0} ^ POLY) : {crc_out[6:0], 1'b0};
        end
    end

endmodule

// File: rtl/crc_frame_rx.sv
// Receive framer: SOF, LEN, payload, CRC byte; forwards payload and reports per-frame status.
// Define CRC_RX_TIMEOUT_EN to abort a frame after TIMEOUT_CYCLES consecutive idle cycles.
module crc_frame_rx
    import crc_pkg::*;
#(
    parameter int unsigned MAX_LEN  = DefaultMaxLen,
    parameter logic [7:0]  SOF_BYTE = DefaultSofByte,
    parameter logic [7:0]  POLY     = DefaultPoly,
    parameter logic [7:0]  CRC_INIT = DefaultCrcInit
`ifdef CRC_RX_TIMEOUT_EN
    , parameter int unsigned TIMEOUT_CYCLES = 64
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       data_valid,
    input  logic [7:0] data_in,
    output logic       data_ready,
    output logic       payload_valid,
    output logic [7:0] payload_out,
    output logic       frame_done,
    output logic       crc_ok,
    output logic       crc_error,
    output logic       len_error,
    output logic [7:0] calculated_crc,
    output logic [7:0] received_crc
);

    localparam int unsigned CntW = len_cnt_width(MAX_LEN);

    rx_state_e       state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [7:0]      crc_q, crc_d;
    logic [7:0]      rcv_q, rcv_d;
    logic            match_q, match_d;
    logic            pv_q, pv_d;
    logic [7:0]      pout_q, pout_d;
    logic [7:0]      crc_step;
    logic            accept;
    logic            len_bad;

    crc8_byte_step #(
        .POLY(POLY)
    ) u_step (
        .crc_in (crc_q),
        .byte_in(data_in),
        .crc_out(crc_step)
    );

    assign data_ready = (state_q != StDone) && (state_q != StErr);
    assign accept     = data_valid && data_ready;
    assign len_bad    = (data_in == 8'd0) || (32'(data_in) > MAX_LEN);

`ifdef CRC_RX_TIMEOUT_EN
    localparam int unsigned IdleW = $clog2(TIMEOUT_CYCLES + 1);

    logic [IdleW-1:0] idle_q, idle_d;
    logic             in_frame;
    logic             timeout;

    assign in_frame = (state_q == StLen) || (state_q == StPayload) || (state_q == StCheck);
    assign idle_d   = (in_frame && !data_valid) ? idle_q + IdleW'(1) : '0;
    assign timeout  = in_frame && !data_valid && (idle_q == IdleW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        crc_d   = crc_q;
        rcv_d   = rcv_q;
        match_d = match_q;
        pv_d    = 1'b0;
        pout_d  = pout_q;
        unique case (state_q)
            StIdle: begin
                // Hunt mode: anything but SOF is dropped.
                if (accept && (data_in == SOF_BYTE)) begin
                    state_d = StLen;
                    crc_d   = CRC_INIT;
                end
            end
            StLen: begin
                if (accept) begin
                    crc_d   = crc_step;
                    cnt_d   = CntW'(data_in);
                    state_d = len_bad ? StErr : StPayload;
                end
            end
            StPayload: begin
                if (accept) begin
                    crc_d  = crc_step;
                    pv_d   = 1'b1;
                    pout_d = data_in;
                    cnt_d  = cnt_q - CntW'(1);
                    if (cnt_q == CntW'(1)) begin
                        state_d = StCheck;
                    end
                end
            end
            StCheck: begin
                if (accept) begin
                    rcv_d   = data_in;
                    match_d = (data_in == crc_q);
                    state_d = StDone;
                end
            end
            StDone, StErr: state_d = StIdle;
            default:       state_d = StIdle;
        endcase
`ifdef CRC_RX_TIMEOUT_EN
        if (timeout) begin
            state_d = StErr;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            crc_q   <= CRC_INIT;
            rcv_q   <= 8'h00;
            match_q <= 1'b0;
            pv_q    <= 1'b0;
            pout_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            crc_q   <= crc_d;
            rcv_q   <= rcv_d;
            match_q <= match_d;
            pv_q    <= pv_d;
            pout_q  <= pout_d;
        end
    end

    assign payload_valid  = pv_q;
    assign payload_out    = pout_q;
    assign frame_done     = (state_q == StDone) || (state_q == StErr);
    assign crc_ok         = (state_q == StDone) && match_q;
    assign crc_error      = (state_q == StDone) && !match_q;
    assign len_error      = (state_q == StErr);
    assign calculated_crc = crc_q;
    assign received_crc   = rcv_q;

endmodule

// File: tb/tb_crc_frame_rx.sv
// Randomized bench for crc_frame_rx against a frame-level model with a per-cycle compare.
module tb_crc_frame_rx;

    typedef logic [7:0] byte_q_t[$];

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       data_valid = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       data_ready;
    logic       payload_valid;
    logic [7:0] payload_out;
    logic       frame_done;
    logic       crc_ok;
    logic       crc_error;
    logic       len_error;
    logic [7:0] calculated_crc;
    logic [7:0] received_crc;

    crc_frame_rx dut (
        .clk           (clk),
        .reset         (reset),
        .data_valid    (data_valid),
        .data_in       (data_in),
        .data_ready    (data_ready),
        .payload_valid (payload_valid),
        .payload_out   (payload_out),
        .frame_done    (frame_done),
        .crc_ok        (crc_ok),
        .crc_error     (crc_error),
        .len_error     (len_error),
        .calculated_crc(calculated_crc),
        .received_crc  (received_crc)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    bit chk_en = 0;

    // One-shot expectations for the cycle after the current edge.
    bit         exp_pv = 0, exp_fd = 0, exp_ok = 0, exp_len = 0, chk_crc = 0;
    logic [7:0] exp_pb = 0, exp_calc = 0, exp_rcv = 0;

    logic [7:0] last_pb = 0, last_calc = 0, last_rcv = 0;
    bit         last_ok = 0, last_err = 0;
    int         fd_cnt = 0, len_cnt = 0, pv_cnt = 0;

    task automatic check1(input string nm, input logic act, input logic req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0b expected %0b at %0t", nm, act, req, $time);
        end
    endtask

    task automatic check8(input string nm, input logic [7:0] act, input logic [7:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %02h expected %02h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic check32(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
        end
    endtask

    // Bit-serial LFSR form of CRC-8 (poly 0x07, init 0x00) over the whole message.
    function automatic logic [7:0] model_crc(input byte_q_t msg);
        logic [7:0] c = 8'h00;
        logic [7:0] b;
        logic       fb;
        foreach (msg[k]) begin
            b = msg[k];
            for (int j = 7; j >= 0; j--) begin
                fb = c[7] ^ b[j];
                c  = {c[6:0], 1'b0};
                if (fb) c = c ^ 8'h07;
            end
        end
        return c;
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (chk_en) begin
                check1("payload_valid", payload_valid, exp_pv);
                if (exp_pv) check8("payload_out", payload_out, exp_pb);
                check1("frame_done", frame_done, exp_fd);
                check1("crc_ok", crc_ok, exp_fd && !exp_len && exp_ok);
                check1("crc_error", crc_error, exp_fd && !exp_len && !exp_ok);
                check1("len_error", len_error, exp_fd && exp_len);
                check1("data_ready", data_ready, !exp_fd);
                if (exp_fd && chk_crc) begin
                    check8("calculated_crc", calculated_crc, exp_calc);
                    check8("received_crc", received_crc, exp_rcv);
                end
                if (payload_valid) begin
                    pv_cnt++;
                    last_pb = payload_out;
                end
                if (frame_done) begin
                    fd_cnt++;
                    if (len_error) len_cnt++;
                    last_ok   = crc_ok;
                    last_err  = crc_error;
                    last_calc = calculated_crc;
                    last_rcv  = received_crc;
                end
            end
            exp_pv  = 0;
            exp_fd  = 0;
            exp_ok  = 0;
            exp_len = 0;
            chk_crc = 0;
        end
    end

    // Present a byte after 'gap' idle cycles; returns just after the accepting edge.
    task automatic drive(input logic [7:0] b, input int gap);
        int guard = 0;
        bit rdy;
        repeat (gap) begin
            @(negedge clk);
            data_valid = 1'b0;
        end
        @(negedge clk);
        data_valid = 1'b1;
        data_in    = b;
        forever begin
            rdy = data_ready;
            @(posedge clk);
            if (rdy) break;
            guard++;
            if (guard > 8) begin
                check1("accept_bound", 1'b0, 1'b1);
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            data_valid = 1'b0;
        end
    endtask

    // crc_sel < 0 sends the correct CRC, otherwise crc_sel[7:0] is sent as the CRC byte.
    task automatic send_frame(input logic [7:0] len_b, input byte_q_t pl, input int crc_sel,
                              input int gap);
        byte_q_t    msg;
        logic [7:0] c;
        logic [7:0] rc;
        drive(8'h7E, gap);
        drive(len_b, gap);
        if (len_b == 8'd0 || len_b > 8'd16) begin
            exp_fd  = 1;
            exp_len = 1;
            return;
        end
        for (int i = 0; i < int'(len_b); i++) begin
            drive(pl[i], gap);
            exp_pv = 1;
            exp_pb = pl[i];
        end
        msg = {len_b};
        msg = {msg, pl};
        c   = model_crc(msg);
        rc  = (crc_sel < 0) ? c : crc_sel[7:0];
        drive(rc, gap);
        exp_fd   = 1;
        exp_ok   = (rc == c);
        exp_calc = c;
        exp_rcv  = rc;
        chk_crc  = 1;
    endtask

    initial begin
        byte_q_t pl;
        int      fd0, l0, p0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #2;
        check1("rst_data_ready", data_ready, 1'b1);
        check1("rst_payload_valid", payload_valid, 1'b0);
        check8("rst_payload_out", payload_out, 8'h00);
        check1("rst_frame_done", frame_done, 1'b0);
        check1("rst_flags", crc_ok | crc_error | len_error, 1'b0);
        check8("rst_calc", calculated_crc, 8'h00);
        check8("rst_rcv", received_crc, 8'h00);
        chk_en = 1;

        // 7E 01 00 15
        pl = {8'h00};
        send_frame(8'h01, pl, 8'h15, 0);
        idle(2);
        check1("f1_ok", last_ok, 1'b1);
        check8("f1_calc", last_calc, 8'h15);
        check8("f1_rcv", last_rcv, 8'h15);
        check8("f1_payload", last_pb, 8'h00);

        // 7E 01 00 14: values hold after the pulse
        send_frame(8'h01, pl, 8'h14, 0);
        idle(5);
        #2;
        check1("f2_err", last_err, 1'b1);
        check8("f2_calc_held", calculated_crc, 8'h15);
        check8("f2_rcv_held", received_crc, 8'h14);
        check1("f2_checker_error", calculated_crc != received_crc, 1'b1);

        // 7E 01 01 12 with 3 idle cycles between bytes
        pl = {8'h01};
        send_frame(8'h01, pl, -1, 3);
        idle(2);
        check1("f3_ok", last_ok, 1'b1);
        check8("f3_payload", last_pb, 8'h01);
        check8("f3_calc", last_calc, 8'h12);

        // Garbage, LEN=0, LEN=17
        fd0 = fd_cnt;
        l0  = len_cnt;
        p0  = pv_cnt;
        drive(8'h00, 0);
        drive(8'hFF, 0);
        pl = {};
        send_frame(8'h00, pl, -1, 0);
        send_frame(8'h11, pl, -1, 0);
        idle(3);
        check32("len_err_pulses", fd_cnt - fd0, 2);
        check32("len_err_flags", len_cnt - l0, 2);
        check32("len_err_payload", pv_cnt - p0, 0);

        // Reset after 7E 01, then a clean frame
        fd0 = fd_cnt;
        drive(8'h7E, 0);
        drive(8'h01, 0);
        @(negedge clk);
        chk_en     = 0;
        data_valid = 1'b0;
        reset      = 1'b0;
        @(negedge clk);
        reset  = 1'b1;
        chk_en = 1;
        pl = {8'h00};
        send_frame(8'h01, pl, 8'h15, 0);
        idle(2);
        check32("reset_abort_pulses", fd_cnt - fd0, 1);
        check1("after_reset_ok", last_ok, 1'b1);

        // Back-to-back frames
        fd0 = fd_cnt;
        pl = {8'h7E, 8'h5A, 8'hC3};
        send_frame(8'h03, pl, -1, 0);
        pl = {8'h10, 8'h7E};
        send_frame(8'h02, pl, -1, 0);
        idle(2);
        check32("b2b_pulses", fd_cnt - fd0, 2);
        check1("b2b_ok", last_ok, 1'b1);

        // Random traffic
        for (int f = 0; f < 60; f++) begin
            logic [7:0] lb;
            logic [7:0] gb;
            int         g;
            repeat ($urandom_range(0, 2)) begin
                do gb = 8'($urandom); while (gb == 8'h7E);
                drive(gb, $urandom_range(0, 1));
            end
            g = $urandom_range(0, 2);
            if ($urandom_range(0, 9) == 0)
                lb = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(17, 255));
            else
                lb = 8'($urandom_range(1, 16));
            pl = {};
            if (lb != 8'd0 && lb <= 8'd16) begin
                for (int i = 0; i < int'(lb); i++)
                    pl.push_back(($urandom_range(0, 7) == 0) ? 8'h7E : 8'($urandom));
            end
            send_frame(lb, pl, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : -1,
                       g);
        end
        idle(3);

        // Idle inside a frame
        fd0 = fd_cnt;
        drive(8'h7E, 0);
        drive(8'h01, 0);
        @(negedge clk);
        data_valid = 1'b0;
`ifdef CRC_RX_TIMEOUT_EN
        repeat (64) @(posedge clk);
        exp_fd  = 1;
        exp_len = 1;
        idle(3);
        check32("timeout_pulse", fd_cnt - fd0, 1);
`else
        idle(200);
        check32("no_timeout_pulse", fd_cnt - fd0, 0);
        drive(8'h00, 0);
        exp_pv = 1;
        exp_pb = 8'h00;
        drive(8'h15, 0);
        exp_fd   = 1;
        exp_ok   = 1;
        exp_calc = 8'h15;
        exp_rcv  = 8'h15;
        chk_crc  = 1;
        idle(3);
        check1("stalled_frame_ok", last_ok, 1'b1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/crc_frame_rx.md
Name: crc_frame_rx

Overview:
- Receive-side framer that sits directly ahead of the CRC check.
- Consumes a raw byte stream framed as SOF, LEN, LEN payload bytes, then one CRC byte.
- Computes CRC-8 over LEN plus payload while forwarding payload bytes cut-through.
- At frame end, presents calculated_crc and received_crc to the existing crc_checker and raises a per-frame status pulse.

Parameters:
- MAX_LEN, 16: largest legal LEN value; legal range is 1..MAX_LEN.
- SOF_BYTE, 8'h7E: start-of-frame marker.
- POLY, 8'h07: CRC-8 polynomial, MSB-first, non-reflected.
- CRC_INIT, 8'h00: CRC seed, loaded at each SOF.
- TIMEOUT_CYCLES, 64: idle-cycle limit; used only with CRC_RX_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous reset, active-low; state is cleared on a clk edge while reset==0.
- data_valid  in  1  data_in holds a byte this cycle.
- data_in  in  8  incoming byte.
- data_ready  out  1  block accepts a byte this cycle; a byte transfers when data_valid && data_ready.
- payload_valid  out  1  payload_out holds a payload byte (one-cycle pulse per byte).
- payload_out  out  8  forwarded payload byte.
- frame_done  out  1  one-cycle pulse when a frame terminates (OK, CRC error or length error).
- crc_ok  out  1  qualified by frame_done; CRC matched.
- crc_error  out  1  qualified by frame_done; CRC mismatch.
- len_error  out  1  qualified by frame_done; LEN==0 or LEN>MAX_LEN.
- calculated_crc  out  8  running CRC, held stable from frame_done until the next SOF.
- received_crc  out  8  captured CRC byte, held stable from frame_done until the next SOF.

Behaviour:
Reset values:
- All outputs are 0 except data_ready, which resets to 1.
- FSM resets to IDLE; running CRC resets to CRC_INIT; byte counter resets to 0.

FSM transitions (state changes only on accepted bytes unless noted):
- IDLE: a byte equal to SOF_BYTE moves to LEN and reloads CRC to CRC_INIT. Any other byte is discarded silently (hunt mode).
- LEN: capture the byte as len and fold it into the CRC.
  - len==0 or len>MAX_LEN -> ERR.
  - Otherwise -> PAYLOAD with counter=len.
- PAYLOAD: fold each byte into the CRC, forward it on payload_out/payload_valid, and decrement the counter. When the counter reaches 1 on an accepted byte -> CHECK.
- CHECK: capture the byte into received_crc (it is not folded into the CRC) and compare against calculated_crc -> DONE.
- DONE (1 cycle): frame_done=1, crc_ok/crc_error set by the comparison, data_ready=0 -> IDLE.
- ERR (1 cycle): frame_done=1, len_error=1, data_ready=0 -> IDLE.

Timing and data rules:
- Output latency: payload_valid/payload_out are registered, 1 cycle after acceptance.
- Status appears on frame_done one cycle after the CRC byte is accepted.
- data_ready is 0 only in DONE and ERR; at most one byte is accepted per cycle.
- CRC update per byte: crc ^= byte, then 8 iterations of {shift left; if the shifted-out MSB was 1, xor POLY}. The whole update completes combinationally in one cycle.
- A SOF_BYTE value inside LEN, PAYLOAD or CHECK is treated as ordinary data; there is no byte stuffing.
- Gaps: data_valid low for any number of cycles inside a frame stalls the FSM with no state change (unless the timeout feature is enabled).
- Reset mid-frame aborts the frame immediately with no frame_done pulse and returns to IDLE.
- Status flags are one-hot and strictly qualified by frame_done; they are 0 in every other cycle.

Optional Feature:
- Macro: CRC_RX_TIMEOUT_EN.
- Defined:
  - An idle counter counts consecutive cycles with data_valid==0 while in LEN, PAYLOAD or CHECK.
  - The counter clears on any accepted byte.
  - When it reaches TIMEOUT_CYCLES, the block pulses frame_done with len_error=1 and returns to IDLE.
- Undefined: no counter logic exists; the FSM waits indefinitely.

Decomposition:
- Shared package crc_pkg holds:
  - the state enum typedef (IDLE, LEN, PAYLOAD, CHECK, DONE, ERR);
  - localparams for the default POLY, CRC_INIT and SOF_BYTE;
  - the length-counter width, derived as clog2(MAX_LEN+1).
- One sub-module: crc8_byte_step, a combinational single-byte CRC update with inputs crc_in[7:0], byte_in[7:0] and parameter POLY, and output crc_out[7:0]. The same step is shared with crc_generator.

Test Plan:
- Frame 7E 01 00 15, one byte per cycle:
  - payload_valid pulses once with 0x00.
  - frame_done with crc_ok=1, calculated_crc=0x15, received_crc=0x15.
- Frame 7E 01 00 14:
  - frame_done with crc_error=1, calculated_crc=0x15, received_crc=0x14.
  - Feeding calculated_crc/received_crc into crc_checker gives error=1.
- Frame 7E 01 01 12, sent with 3 idle cycles between every byte:
  - crc_ok=1; payload_out=0x01.
  - No status pulses during the gaps.
- Garbage 00 FF 7E 00 (LEN=0), then 7E 11 (LEN=17 > MAX_LEN):
  - The leading bytes are ignored.
  - Two frame_done pulses, each with len_error=1; no payload_valid.
- Reset mid-frame and back-to-back frames:
  - reset=0 for one cycle after 7E 01 is accepted: no frame_done; a following 7E 01 00 15 yields crc_ok=1.
  - Back-to-back frames: data_ready drops for exactly the DONE cycle, and both frames report crc_ok.
- With CRC_RX_TIMEOUT_EN defined:
  - Send 7E 01, then hold data_valid=0: frame_done with len_error=1 exactly 64 cycles later.
  - Without the macro, no pulse after 200 cycles.
